cp0_exc_ctrl: RTL

Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline. It sits alongside the M stage and owns the SR, Cause, EPC and PRId registers. It arbitrates hardware interrupts against synchronous exceptions reported by the pipeline and raises the single-cycle redirect request that forces the next-PC logic to HANDLER_ADDR. It also supplies EPC as the eret return target.

---
 rtl/cp0_pkg.sv | 26 ++
 rtl/cp0_exc_ctrl_irq_arb.sv | 24 ++
 rtl/cp0_exc_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, field bit positions and ExcCode values.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int IM_HI  = 15;
    localparam int IM_LO  = 10;
    localparam int EXL    = 1;
    localparam int IE     = 0;
    localparam int BD     = 31;
    localparam int EXC_HI = 6;
    localparam int EXC_LO = 2;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

endpackage

// File: rtl/cp0_exc_ctrl_irq_arb.sv
// Combinational arbitration between enabled hardware interrupts and pipeline exceptions.
module cp0_irq_arb
    import cp0_pkg::*;
(
    input  logic [5:0] hw_int,
    input  logic [5:0] im,
    input  logic       ie,
    input  logic       exl,
    input  logic [4:0] exc_code_in,
    output logic       int_req,
    output logic       exc_req,
    output logic       req,
    output logic [4:0] next_exc_code
);

    // Raw interrupt lines are used so an interrupt is taken the same cycle it appears.
    assign int_req = (|(hw_int & im)) & ie & ~exl;
    assign exc_req = (exc_code_in != 5'd0) & ~exl;
    assign req     = int_req | exc_req;

    // An interrupt outranks a synchronous exception in the same cycle.
    assign next_exc_code = int_req ? EXC_INT : exc_code_in;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: owns SR, Cause, EPC and PRId beside the M stage.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL     = 32'h0000_0913
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic        exl_clr,
    input  logic [5:0]  hw_int,
    output logic        req,
    output logic [31:0] handler_pc,
    output logic [31:0] epc_out
);

    logic [5:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic [5:0]  ip_q;
    logic [4:0]  exc_code_q;
    logic [31:0] epc_q;

    logic        int_req;
    logic        exc_req;
    logic [4:0]  next_exc_code;
    logic [31:0] vpc_aligned;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    cp0_irq_arb u_arb (
        .hw_int        (hw_int),
        .im            (im_q),
        .ie            (ie_q),
        .exl           (exl_q),
        .exc_code_in   (exc_code_in),
        .int_req       (int_req),
        .exc_req       (exc_req),
        .req           (req),
        .next_exc_code (next_exc_code)
    );

    assign handler_pc  = HANDLER_ADDR;
    assign vpc_aligned = vpc & 32'hFFFF_FFFC;

    // A same-cycle mtc0 to EPC is forwarded so eret may immediately follow it.
    assign epc_out = (we && cp0_addr == REG_EPC) ? cp0_wdata : epc_q;

    // Assemble the architecturally visible SR and Cause words; unused bits read 0.
    always_comb begin
        sr_val                 = 32'd0;
        sr_val[IM_HI:IM_LO]    = im_q;
        sr_val[EXL]            = exl_q;
        sr_val[IE]             = ie_q;
        cause_val              = 32'd0;
        cause_val[BD]          = bd_q;
        cause_val[IM_HI:IM_LO] = ip_q;
        cause_val[EXC_HI:EXC_LO] = exc_code_q;
    end

    // mfc0 read mux shows pre-edge contents only.
    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            REG_SR:    cp0_rdata = sr_val;
            REG_CAUSE: cp0_rdata = cause_val;
            REG_EPC:   cp0_rdata = epc_q;
            REG_PRID:  cp0_rdata = PRID_VAL;
            default:   cp0_rdata = 32'd0;
        endcase
    end

    // Register update: exception entry beats mtc0/eret; eret clears EXL after any SR write.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= 6'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= 6'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
        end else begin
            ip_q <= hw_int;
            if (req) begin
                exl_q      <= 1'b1;
                bd_q       <= bd_in;
                exc_code_q <= next_exc_code;
                epc_q      <= bd_in ? (vpc_aligned - 32'd4) : vpc_aligned;
            end else begin
                if (we && cp0_addr == REG_SR) begin
                    im_q  <= cp0_wdata[IM_HI:IM_LO];
                    exl_q <= cp0_wdata[EXL];
                    ie_q  <= cp0_wdata[IE];
                end
                if (we && cp0_addr == REG_EPC) begin
                    epc_q <= cp0_wdata;
                end
                if (exl_clr) begin
                    exl_q <= 1'b0;
                end
            end
        end
    end

endmodule
